// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with registered one-hot grant and hold timeout
module rr_arbiter_8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t     state, state_n;
    logic [2:0] ptr, ptr_n, win, idx_n, cand;
    logic [7:0] cnt, cnt_n;
    logic       found, hit_limit, rel, arb, to_n;

    // first active requester searching ptr, ptr+1, ... with wrap-around
    always_comb begin
        found = 1'b0;
        win = ptr;
        cand = ptr;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win = cand;
            end
        end
    end

    // release decision, next grant, pointer and hold counter
    always_comb begin
        hit_limit = cnt == 8'(HOLD_MAX - 1);
        rel = (state == BUSY) && (done || !req[gnt_idx] || hit_limit);
        arb = (state == IDLE) || rel;
        state_n = arb ? (found ? BUSY : IDLE) : state;
        ptr_n = (arb && found) ? win + 3'd1 : ptr;
        idx_n = (arb && found) ? win : gnt_idx;
        cnt_n = arb ? 8'd0 : cnt + 8'd1;
        to_n = rel && !done && req[gnt_idx];
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            cnt       <= 8'd0;
            gnt_idx   <= 3'd0;
            gnt       <= 8'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            gnt_idx   <= idx_n;
            gnt       <= (state_n == BUSY) ? 8'b1 << idx_n : 8'd0;
            gnt_valid <= state_n == BUSY;
            timeout   <= to_n;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: scoreboard bench for the round-robin arbiter against a behavioural model
module tb_rr_arbiter_8;
    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter_8 #(.HOLD_MAX(HM)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] g;
        logic [2:0] i;
        logic       v;
        logic       t;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    int owner = -1;
    int last = 0;
    int ptr = 0;
    int hold = 0;
    int to = 0;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic model(input logic [7:0] r, input logic d, input logic rn);
        int w;
        bit again;
        if (!rn) begin
            owner = -1; last = 0; ptr = 0; hold = 0; to = 0;
            return;
        end
        to = 0;
        again = 0;
        if (owner < 0) again = 1;
        else if (d) again = 1;
        else if (!r[owner]) again = 1;
        else if (hold == HM - 1) begin again = 1; to = 1; end
        else hold++;
        if (again) begin
            w = pick(r, ptr);
            if (w >= 0) begin
                owner = w; last = w; ptr = (w + 1) % 8; hold = 0;
            end else owner = -1;
        end
    endtask

    task automatic step(input logic [7:0] r, input logic d, input logic rn);
        exp_t e;
        @(negedge clk);
        req = r; done = d; reset_n = rn;
        model(r, d, rn);
        e.v = owner >= 0;
        e.g = e.v ? 8'(1 << owner) : 8'd0;
        e.i = 3'(last);
        e.t = to != 0;
        q.push_back(e);
    endtask

    // monitor: compare DUT outputs just after each edge with the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (gnt !== e.g || gnt_idx !== e.i || gnt_valid !== e.v || timeout !== e.t) begin
                    bad++;
                    $display("FAIL grant cyc=%0d got gnt=%h idx=%0d valid=%b timeout=%b want gnt=%h idx=%0d valid=%b timeout=%b",
                             cyc, gnt, gnt_idx, gnt_valid, timeout, e.g, e.i, e.v, e.t);
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        // reset then single request, release with done and req cleared
        step(8'h00, 0, 0);
        step(8'h00, 0, 0);
        step(8'h04, 0, 1);
        step(8'h00, 1, 1);
        // rotation with all requesting, done every third cycle
        step(8'h00, 0, 0);
        for (int i = 0; i < 27; i++) step(8'hFF, (i % 3) == 2, 1);
        // wrap priority
        step(8'h00, 0, 0);
        step(8'h40, 0, 1);
        step(8'h00, 1, 1);
        step(8'h41, 0, 1);
        step(8'h41, 0, 1);
        // timeout handover
        step(8'h00, 0, 0);
        for (int i = 0; i < 10; i++) step(8'h09, 0, 1);
        // done coinciding with the limit cycle
        step(8'h00, 0, 0);
        for (int i = 0; i < 6; i++) step(8'h09, i == 3, 1);
        // owner drops its request
        step(8'h00, 0, 0);
        step(8'h20, 0, 1);
        step(8'h21, 0, 1);
        step(8'h01, 0, 1);
        step(8'h01, 0, 1);
        // reset mid-grant
        step(8'h00, 0, 0);
        step(8'h08, 0, 1);
        step(8'h08, 0, 1);
        step(8'h08, 0, 1);
        step(8'h08, 0, 0);
        step(8'h18, 0, 1);
        step(8'h18, 0, 1);
        // randomized traffic
        r = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0)
                r = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            step(r, $urandom_range(0, 5) == 0, $urandom_range(0, 60) != 0);
        end
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got pending=%0d want pending=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
